smart_mac_lin_ctrl: RTL and testbench

//  Sequencer for one NUM_ROWS x NUM_COLS tile of smart_mac_lin cells.

---
 rtl/smart_mac_lin_ctrl_pkg.sv | 32 +++
 rtl/smart_mac_lin_ctrl_phase_cnt.sv | 42 ++++
 rtl/smart_mac_lin_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_smart_mac_lin_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_mac_lin_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// smart_mac_lin_ctrl_pkg
// Shared definitions for the smart_mac_lin tile sequencer:
//   - ctrl_state_e : 3-bit sequencer state encoding
//   - OP2_ACC / OP2_TOP / OUT_PSUM : select values driven to the MAC array
//   - calcSkew()   : wavefront settle time of a rows x cols systolic tile
// No ports; imported by smart_mac_lin_ctrl.
// ---------------------------------------------------------------------------
package smart_mac_lin_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } ctrl_state_e;

  // MAC operand-2 select: accumulate own register vs. take top_in
  localparam logic OP2_ACC  = 1'b0;
  localparam logic OP2_TOP  = 1'b1;
  // MAC output select: drive accumulator onto bottom_out
  localparam logic OUT_PSUM = 1'b1;

  // The last partial sum leaves the far corner of the tile this many cycles
  // after the last operand enters the near corner.
  function automatic int calcSkew(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/smart_mac_lin_ctrl_phase_cnt.sv
// ---------------------------------------------------------------------------
// smart_mac_lin_ctrl_phase_cnt
// Clearable, enable-gated phase counter with a terminal-match flag. The
// sequencer reloads the terminal value per phase and clears the count on
// every phase change, so a single instance times all phases.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset (count -> 0)
//   i_clear  in  1      force count to 0 (wins over enable)
//   i_enable in  1      advance count by one
//   i_term   in  CNT_W  terminal value to compare against
//   o_match  out 1      count equals terminal value (exact compare, no wrap)
// ---------------------------------------------------------------------------
module smart_mac_lin_ctrl_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_match
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Clear has priority so a phase ending on an enabled beat restarts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_match = (r_count == i_term);

endmodule

// File: rtl/smart_mac_lin_ctrl.sv
// ---------------------------------------------------------------------------
// smart_mac_lin_ctrl
// Sequencer for one NUM_ROWS x NUM_COLS tile of smart_mac_lin cells. Takes a
// job config from the tile scheduler, then steps LOAD -> COMPUTE -> FLUSH ->
// DRAIN -> DONE while driving the broadcast MAC controls and the per-column
// smart-bus bypass selects. All outputs are registered.
// Optional feature macro: SMART_MAC_CTRL_PERF_EN adds performance counters.
// Ports:
//   clk, rst                   clock / synchronous active-high reset
//   perf_busy_cnt_out[31:0]    (PERF only) cycles busy for the current job
//   perf_stall_cnt_out[31:0]   (PERF only) COMPUTE cycles without a beat
//   cfg_valid_in/ready_out     config handshake, ready only in IDLE
//   cfg_k_len_in               compute beats for the job
//   cfg_stationary_in          1 = run the weight LOAD phase
//   cfg_bypass_mask_in         per-column smart-bus left-input select
//   start_in                   launch job (IDLE only)
//   in_valid_in                operand beat valid during COMPUTE
//   busy_out / done_out        job in flight / one-cycle end pulse
//   fsm_op2_select_out         MAC operand-2 select
//   fsm_out_select_out         MAC output select
//   stat_bit_out               MAC latch-stationary-operand strobe
//   select_left_in_smart_out   per-column left-input bus select
// ---------------------------------------------------------------------------
module smart_mac_lin_ctrl
  import smart_mac_lin_ctrl_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int K_CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SMART_MAC_CTRL_PERF_EN
  output logic [31:0]         perf_busy_cnt_out,
  output logic [31:0]         perf_stall_cnt_out,
`endif
  input  logic                cfg_valid_in,
  output logic                cfg_ready_out,
  input  logic [K_CNT_W-1:0]  cfg_k_len_in,
  input  logic                cfg_stationary_in,
  input  logic [NUM_COLS-1:0] cfg_bypass_mask_in,
  input  logic                start_in,
  input  logic                in_valid_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                fsm_op2_select_out,
  output logic                fsm_out_select_out,
  output logic                stat_bit_out,
  output logic [NUM_COLS-1:0] select_left_in_smart_out
);

  localparam int               SKEW      = calcSkew(NUM_ROWS, NUM_COLS);
  localparam logic [K_CNT_W-1:0] ROWS_TERM = K_CNT_W'(NUM_ROWS - 1);
  localparam logic [K_CNT_W-1:0] SKEW_TERM = K_CNT_W'((SKEW > 0) ? SKEW - 1 : 0);
  localparam logic [K_CNT_W-1:0] K_ONE     = K_CNT_W'(1);

  ctrl_state_e         r_state;
  ctrl_state_e         w_nextState;
  logic [K_CNT_W-1:0]  r_kLen;
  logic                r_stat;
  logic [NUM_COLS-1:0] r_mask;

  logic                w_cfgAccept;
  logic                w_startAccept;
  logic [K_CNT_W-1:0]  w_jobK;
  logic                w_jobStat;
  logic [NUM_COLS-1:0] w_jobMask;
  logic [K_CNT_W-1:0]  w_term;
  logic                w_cntEn;
  logic                w_cntMatch;
  logic                w_phaseEnd;
  logic                w_cntClear;

  // A config offered in the same cycle as start must be the one the job
  // runs with, so the launch decision looks through the config registers.
  always_comb begin
    w_cfgAccept   = cfg_valid_in && (r_state == ST_IDLE);
    w_startAccept = start_in && (r_state == ST_IDLE);
    w_jobK        = w_cfgAccept ? cfg_k_len_in       : r_kLen;
    w_jobStat     = w_cfgAccept ? cfg_stationary_in  : r_stat;
    w_jobMask     = w_cfgAccept ? cfg_bypass_mask_in : r_mask;
  end

  // Per-phase terminal value and counting enable. COMPUTE only counts real
  // operand beats, so a stall simply freezes the phase.
  always_comb begin
    w_term  = '0;
    w_cntEn = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_term  = ROWS_TERM;
        w_cntEn = 1'b1;
      end
      ST_COMPUTE: begin
        w_term  = r_kLen - K_ONE;
        w_cntEn = in_valid_in;
      end
      ST_FLUSH: begin
        w_term  = SKEW_TERM;
        w_cntEn = 1'b1;
      end
      ST_DRAIN: begin
        w_term  = ROWS_TERM;
        w_cntEn = 1'b1;
      end
      default: begin
        w_term  = '0;
        w_cntEn = 1'b0;
      end
    endcase
    w_phaseEnd = w_cntMatch && w_cntEn;
    w_cntClear = w_phaseEnd || (r_state == ST_IDLE) || (r_state == ST_DONE);
  end

  smart_mac_lin_ctrl_phase_cnt #(
    .CNT_W(K_CNT_W)
  ) u_phaseCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cntClear),
    .i_enable(w_cntEn),
    .i_term  (w_term),
    .o_match (w_cntMatch)
  );

  // Phase sequencing. Empty jobs (k_len 0) skip COMPUTE and FLUSH, and a
  // zero-skew tile skips FLUSH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          if (w_jobStat) begin
            w_nextState = ST_LOAD;
          end else if (w_jobK == '0) begin
            w_nextState = ST_DRAIN;
          end else begin
            w_nextState = ST_COMPUTE;
          end
        end
      end
      ST_LOAD: begin
        if (w_phaseEnd) begin
          w_nextState = (r_kLen == '0) ? ST_DRAIN : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (w_phaseEnd) begin
          w_nextState = (SKEW == 0) ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_phaseEnd) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_phaseEnd) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, config registers and registered outputs. Outputs are decoded from
  // the state being entered so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                  <= ST_IDLE;
      r_kLen                   <= '0;
      r_stat                   <= 1'b0;
      r_mask                   <= '0;
      cfg_ready_out            <= 1'b1;
      busy_out                 <= 1'b0;
      done_out                 <= 1'b0;
      fsm_op2_select_out       <= OP2_ACC;
      fsm_out_select_out       <= 1'b0;
      stat_bit_out             <= 1'b0;
      select_left_in_smart_out <= '0;
    end else begin
      if (w_cfgAccept) begin
        r_kLen <= cfg_k_len_in;
        r_stat <= cfg_stationary_in;
        r_mask <= cfg_bypass_mask_in;
      end
      r_state            <= w_nextState;
      cfg_ready_out      <= (w_nextState == ST_IDLE);
      busy_out           <= (w_nextState != ST_IDLE);
      done_out           <= (w_nextState == ST_DONE);
      fsm_op2_select_out <= ((w_nextState == ST_LOAD) || (w_nextState == ST_DRAIN))
                            ? OP2_TOP : OP2_ACC;
      fsm_out_select_out <= (w_nextState == ST_DRAIN) ? OUT_PSUM : 1'b0;
      stat_bit_out       <= (w_nextState == ST_LOAD);
      if ((w_nextState == ST_IDLE) || (w_nextState == ST_DONE)) begin
        select_left_in_smart_out <= '0;
      end else begin
        select_left_in_smart_out <= w_jobMask;
      end
    end
  end

`ifdef SMART_MAC_CTRL_PERF_EN
  // The accept cycle is counted as the job's first busy cycle, so the busy
  // count equals the start-to-done job length. Both counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cnt_out  <= '0;
      perf_stall_cnt_out <= '0;
    end else if (w_startAccept) begin
      perf_busy_cnt_out  <= 32'd1;
      perf_stall_cnt_out <= '0;
    end else begin
      if (busy_out && (perf_busy_cnt_out != '1)) begin
        perf_busy_cnt_out <= perf_busy_cnt_out + 32'd1;
      end
      if ((r_state == ST_COMPUTE) && !in_valid_in && (perf_stall_cnt_out != '1)) begin
        perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
      end
    end
  end
`else
  // Without the performance counters the start-accept strobe has no user.
  logic w_unusedStart;
  assign w_unusedStart = w_startAccept;
`endif

endmodule

// File: tb/tb_smart_mac_lin_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smart_mac_lin_ctrl
// Self-checking bench for smart_mac_lin_ctrl (4x4 tile). Each job's expected
// profile (phase lengths, done cycle, mask) is derived from the job config
// and the operand-valid plan, pushed into a queue, and checked by a monitor
// that tracks the DUT outputs from busy rise to the done pulse.
// ---------------------------------------------------------------------------
module tb_smart_mac_lin_ctrl;

  localparam int R        = 4;
  localparam int C        = 4;
  localparam int SKEW     = R + C - 2;
  localparam int PLAN_LEN = 300;
  localparam int MAX_CYC  = 250;

  typedef struct {
    int         doneCyc;
    int         statCyc;
    int         op2ZeroCyc;
    int         outSelCyc;
    int         stalls;
    logic [3:0] mask;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid_in;
  logic        cfg_ready_out;
  logic [15:0] cfg_k_len_in;
  logic        cfg_stationary_in;
  logic [3:0]  cfg_bypass_mask_in;
  logic        start_in;
  logic        in_valid_in;
  logic        busy_out;
  logic        done_out;
  logic        fsm_op2_select_out;
  logic        fsm_out_select_out;
  logic        stat_bit_out;
  logic [3:0]  select_left_in_smart_out;
`ifdef SMART_MAC_CTRL_PERF_EN
  logic [31:0] perf_busy_cnt_out;
  logic [31:0] perf_stall_cnt_out;
`endif

  int  nTests = 0;
  int  nFail  = 0;
  expT expQ[$];
  bit  plan[0:PLAN_LEN-1];
  int  mdlK;
  bit  mdlStat;
  logic [3:0] mdlMask;

  int  monCyc, monStat, monOp2Zero, monOutSel, monMaskBad;
  bit  monActive = 1'b0;
  bit  monPost   = 1'b0;
  logic [3:0] monMask;

  smart_mac_lin_ctrl #(
    .NUM_ROWS(R),
    .NUM_COLS(C),
    .K_CNT_W (16)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
`ifdef SMART_MAC_CTRL_PERF_EN
    .perf_busy_cnt_out       (perf_busy_cnt_out),
    .perf_stall_cnt_out      (perf_stall_cnt_out),
`endif
    .cfg_valid_in            (cfg_valid_in),
    .cfg_ready_out           (cfg_ready_out),
    .cfg_k_len_in            (cfg_k_len_in),
    .cfg_stationary_in       (cfg_stationary_in),
    .cfg_bypass_mask_in      (cfg_bypass_mask_in),
    .start_in                (start_in),
    .in_valid_in             (in_valid_in),
    .busy_out                (busy_out),
    .done_out                (done_out),
    .fsm_op2_select_out      (fsm_op2_select_out),
    .fsm_out_select_out      (fsm_out_select_out),
    .stat_bit_out            (stat_bit_out),
    .select_left_in_smart_out(select_left_in_smart_out)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself gets stuck
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Job profile from the rules: LOAD takes R cycles when stationary; COMPUTE
  // lasts until k valid beats have been seen; FLUSH SKEW; DRAIN R; DONE 1.
  // Cycle 1 is the first cycle after the start is accepted.
  function automatic expT buildExpect(input int k, input bit st, input logic [3:0] m);
    expT e;
    int  j;
    int  beats;
    e.stalls = 0;
    if (k > 0) begin
      j     = 1 + (st ? R : 0);
      beats = 0;
      while (beats < k && j < PLAN_LEN) begin
        if (plan[j]) beats++;
        else e.stalls++;
        j++;
      end
    end
    e.statCyc    = st ? R : 0;
    e.op2ZeroCyc = (k > 0) ? k + e.stalls + SKEW : 0;
    e.outSelCyc  = R;
    e.doneCyc    = e.statCyc + e.op2ZeroCyc + R + 1;
    e.mask       = m;
    return e;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"},  busy_out, 0);
    checkOutput({tag, "Done"},  done_out, 0);
    checkOutput({tag, "Op2"},   fsm_op2_select_out, 0);
    checkOutput({tag, "OutSel"}, fsm_out_select_out, 0);
    checkOutput({tag, "Stat"},  stat_bit_out, 0);
    checkOutput({tag, "Mask"},  select_left_in_smart_out, 0);
    checkOutput({tag, "Ready"}, cfg_ready_out, 1);
  endtask

  // cfgMode: 0 = start only (reuse config), 1 = cfg with start,
  //          2 = cfg one cycle ahead of start.
  // planMode: 0 = always valid, 1 = random, 2 = stall on cycles 8..10.
  // poke: at cycle 3 offer a different config and a start while busy.
  task automatic applyStimulus(input int k, input bit st, input logic [3:0] m,
                               input int cfgMode, input int planMode, input bit poke);
    expT e;
    bit  seen;
    for (int j = 0; j < PLAN_LEN; j++) begin
      case (planMode)
        0:       plan[j] = 1'b1;
        1:       plan[j] = ($urandom_range(0, 3) != 0);
        default: plan[j] = !(j >= 8 && j <= 10);
      endcase
    end
    if (cfgMode != 0) begin
      mdlK    = k;
      mdlStat = st;
      mdlMask = m;
    end
    e = buildExpect(mdlK, mdlStat, mdlMask);
    expQ.push_back(e);
    cfg_k_len_in       = 16'(k);
    cfg_stationary_in  = st;
    cfg_bypass_mask_in = m;
    in_valid_in        = 1'b0;
    if (cfgMode == 2) begin
      cfg_valid_in = 1'b1;
      @(posedge clk); #1;
    end
    cfg_valid_in = (cfgMode == 1);
    start_in     = 1'b1;
    @(posedge clk); #1;
    cfg_valid_in = 1'b0;
    start_in     = 1'b0;
    seen = 1'b0;
    for (int j = 1; j < MAX_CYC && !seen; j++) begin
      in_valid_in = plan[j];
      if (poke && j == 3) begin
        start_in           = 1'b1;
        cfg_valid_in       = 1'b1;
        cfg_k_len_in       = 16'd3;
        cfg_stationary_in  = !mdlStat;
        cfg_bypass_mask_in = ~mdlMask;
      end
      @(negedge clk);
      if (poke && j == 3) checkOutput("cfgReadyWhileBusy", cfg_ready_out, 0);
      if (done_out) seen = 1'b1;
      @(posedge clk); #1;
      start_in     = 1'b0;
      cfg_valid_in = 1'b0;
      in_valid_in  = 1'b0;
    end
    if (!seen) begin
      checkOutput("jobTimeout", 0, 1);
      expQ.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
`ifdef SMART_MAC_CTRL_PERF_EN
      checkOutput("perfBusy",  perf_busy_cnt_out,  e.doneCyc + 1);
      checkOutput("perfStall", perf_stall_cnt_out, e.stalls);
`endif
    end
  endtask

  // Monitor: profiles each job from busy rise and scores it on done.
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      monActive = 1'b0;
      monPost   = 1'b0;
    end else begin
      if (monPost) begin
        checkOutput("postDoneBusy",  busy_out, 0);
        checkOutput("postDoneReady", cfg_ready_out, 1);
        checkOutput("postDoneDone",  done_out, 0);
        monPost = 1'b0;
      end
      if (busy_out && !monActive) begin
        monActive  = 1'b1;
        monCyc     = 0;
        monStat    = 0;
        monOp2Zero = 0;
        monOutSel  = 0;
        monMaskBad = 0;
        monMask    = select_left_in_smart_out;
      end
      if (monActive) begin
        monCyc++;
        if (!busy_out) checkOutput("busyDrop", busy_out, 1);
        if (cfg_ready_out) checkOutput("readyWhileBusy", cfg_ready_out, 0);
        if (!done_out) begin
          if (stat_bit_out) monStat++;
          if (!fsm_op2_select_out) monOp2Zero++;
          if (fsm_out_select_out) monOutSel++;
          if (select_left_in_smart_out !== monMask) monMaskBad++;
        end else begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("doneCycle",     monCyc,     e.doneCyc);
            checkOutput("statCycles",    monStat,    e.statCyc);
            checkOutput("op2ZeroCycles", monOp2Zero, e.op2ZeroCyc);
            checkOutput("outSelCycles",  monOutSel,  e.outSelCyc);
            checkOutput("maskValue",     monMask,    e.mask);
            checkOutput("maskStable",    monMaskBad, 0);
            checkOutput("doneMaskZero",  select_left_in_smart_out, 0);
            checkOutput("doneOp2",       fsm_op2_select_out, 0);
          end
          monActive = 1'b0;
          monPost   = 1'b1;
        end
      end else if (done_out) begin
        checkOutput("strayDone", 1, 0);
      end
    end
  end

  initial begin
    rst                = 1'b1;
    cfg_valid_in       = 1'b0;
    cfg_k_len_in       = '0;
    cfg_stationary_in  = 1'b0;
    cfg_bypass_mask_in = '0;
    start_in           = 1'b0;
    in_valid_in        = 1'b0;
    mdlK               = 0;
    mdlStat            = 1'b0;
    mdlMask            = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk); #1;

    // Nominal stationary job, then the same job with a 3-cycle stall
    applyStimulus(8, 1'b1, 4'b0101, 1, 0, 1'b0);
    applyStimulus(8, 1'b1, 4'b0101, 1, 2, 1'b0);
    // Empty job: straight to DRAIN
    applyStimulus(0, 1'b0, 4'b1010, 1, 0, 1'b0);
    // Config and start offered while busy are ignored; next start reuses config
    applyStimulus(5, 1'b1, 4'b0011, 1, 1, 1'b1);
    applyStimulus(7, 1'b0, 4'b1111, 0, 1, 1'b0);

    // Reset in the middle of COMPUTE: no done, clean outputs, config cleared
    cfg_valid_in       = 1'b1;
    cfg_k_len_in       = 16'd20;
    cfg_stationary_in  = 1'b0;
    cfg_bypass_mask_in = 4'b1111;
    start_in           = 1'b1;
    in_valid_in        = 1'b1;
    @(posedge clk); #1;
    cfg_valid_in = 1'b0;
    start_in     = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    in_valid_in = 1'b0;
    mdlK        = 0;
    mdlStat     = 1'b0;
    mdlMask     = '0;
    @(negedge clk);
    checkResetState("midJobReset");
    repeat (10) @(posedge clk);
    #1;
    // After reset the cleared config gives an empty, non-stationary job
    applyStimulus(9, 1'b1, 4'b1001, 0, 0, 1'b0);
    applyStimulus(6, 1'b0, 4'b0110, 1, 1, 1'b0);

    // Randomized jobs
    for (int n = 0; n < 14; n++) begin
      applyStimulus($urandom_range(0, 12), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 2), 1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
